// File: rtl/fp_pkg.sv
// Shared definitions for the sequential FP divider.
// Holds the IEEE-754 single-precision field widths, the exponent bias,
// the saturated exponent code and the divider control state encoding.
package fp_pkg;

    localparam int BIAS       = 127;
    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int MANT_W     = FRAC_W + 1;

    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp_mant_div.sv
// Restoring mantissa divider core, one quotient bit per clock.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture dividend m1 and divisor m2, clear quotient/count
//   step       : produce one quotient bit
//   m1, m2     : 24-bit mantissas with the hidden bit set
//   q          : ITER-bit quotient, 1 integer bit then ITER-1 fraction bits
//   ready      : the current step produces the final quotient bit
module fp_mant_div
    import fp_pkg::*;
#(
    parameter int ITER = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] m1,
    input  logic [MANT_W-1:0] m2,
    output logic [ITER-1:0]   q,
    output logic              ready
);

    // Remainder carries one extra bit: it stays below 2*D, so the shifted
    // value always fits without loss.
    logic [MANT_W:0]   rem;
    logic [MANT_W-1:0] dvs;
    logic [4:0]        count;
    logic [MANT_W:0]   diff;
    logic              ge;

    assign ge    = (rem >= {1'b0, dvs});
    assign diff  = rem - {1'b0, dvs};
    assign ready = (count == 5'(ITER - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem   <= '0;
            dvs   <= '0;
            q     <= '0;
            count <= '0;
        end else if (load) begin
            rem   <= {1'b0, m1};
            dvs   <= m2;
            q     <= '0;
            count <= '0;
        end else if (step) begin
            if (ge) begin
                q   <= {q[ITER-2:0], 1'b1};
                rem <= {diff[MANT_W-1:0], 1'b0};
            end else begin
                q   <= {q[ITER-2:0], 1'b0};
                rem <= {rem[MANT_W-1:0], 1'b0};
            end
            count <= count + 5'd1;
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider, out = in1 / in2.
// Truncating, denormals flushed to zero, NaN/Inf not specially handled.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : request, accepted only while idle; in1/in2 sampled then
//   in1, in2    : dividend, divisor
//   busy        : operation in progress (cycle after acceptance until done)
//   done        : one-cycle pulse, out valid
//   out         : quotient, held until the next accepted start
//   div_by_zero : in2 was zero
//   overflow    : result saturated to infinity
//
// state  | meaning
// IDLE   | waiting for start
// DIVIDE | mantissa core producing one quotient bit per cycle
// NORM   | normalise, range-check and write out (skipped for zero operands)
// DONE   | done pulse, busy already low
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ITER       = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  div_by_zero,
    output logic                  overflow
);

    state_t state;

    logic              sign_r;
    logic signed [9:0] exp_r;
    logic              bypass_r;

    logic [EXP_W-1:0]  exp1;
    logic [EXP_W-1:0]  exp2;
    logic              sign_in;
    logic signed [9:0] exp_in;

    logic              mant_load;
    logic              mant_step;
    logic [ITER-1:0]   q;
    logic              ready;

    logic signed [9:0] exp_adj;
    logic [FRAC_W-1:0] frac_n;

    assign exp1    = in1[DATA_WIDTH-2 -: EXP_W];
    assign exp2    = in2[DATA_WIDTH-2 -: EXP_W];
    assign sign_in = in1[DATA_WIDTH-1] ^ in2[DATA_WIDTH-1];
    assign exp_in  = $signed({2'b00, exp1}) - $signed({2'b00, exp2}) + 10'(BIAS);

    assign mant_load = (state == IDLE) && start && (exp1 != '0) && (exp2 != '0);
    assign mant_step = (state == DIVIDE);

    fp_mant_div #(
        .ITER (ITER)
    ) u_mant_div (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mant_load),
        .step  (mant_step),
        .m1    ({1'b1, in1[FRAC_W-1:0]}),
        .m2    ({1'b1, in2[FRAC_W-1:0]}),
        .q     (q),
        .ready (ready)
    );

    // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left
    // shift is needed, paid for by decrementing the exponent.
    always_comb begin
        exp_adj = exp_r;
        frac_n  = q[FRAC_W-1:0];
        if (q[ITER-1]) begin
            frac_n = q[FRAC_W:1];
        end else begin
            exp_adj = exp_r - 10'sd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            out         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
            bypass_r    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        sign_r      <= sign_in;
                        exp_r       <= exp_in;
                        if (exp2 == '0) begin
                            out         <= {sign_in, EXP_INF, {FRAC_W{1'b0}}};
                            div_by_zero <= 1'b1;
                            bypass_r    <= 1'b1;
                            state       <= NORM;
                        end else if (exp1 == '0) begin
                            out      <= {sign_in, {(DATA_WIDTH-1){1'b0}}};
                            bypass_r <= 1'b1;
                            state    <= NORM;
                        end else begin
                            bypass_r <= 1'b0;
                            state    <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (ready) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (!bypass_r) begin
                        if (exp_adj >= 10'sd255) begin
                            out      <= {sign_r, EXP_INF, {FRAC_W{1'b0}}};
                            overflow <= 1'b1;
                        end else if (exp_adj <= 10'sd0) begin
                            out <= {sign_r, {(DATA_WIDTH-1){1'b0}}};
                        end else begin
                            out <= {sign_r, exp_adj[EXP_W-1:0], frac_n};
                        end
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed vector table, random
// operands against an arithmetic reference, and handshake corner cases.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        div_by_zero;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int LAT_NORMAL = 26;   // done first seen 26 edges after the accept edge (cycle T+27)
    localparam int LAT_BYPASS = 1;    // cycle T+2
    localparam int MAX_WAIT   = 60;

    fp_div_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in1         (in1),
        .in2         (in2),
        .busy        (busy),
        .done        (done),
        .out         (out),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_dbz;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Reference: exact integer quotient of the mantissas with 24 fraction
    // bits (truncated), then normalise and range-check.
    function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic   sgn;
        int     ea, eb, e;
        longint ma, mb, qv, frac;
        sgn = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        if (eb == 0) return {1'b1, 1'b0, sgn, 8'hFF, 23'h0};
        if (ea == 0) return {1'b0, 1'b0, sgn, 31'h0};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        qv = (ma * 64'd16777216) / mb;
        e  = ea - eb + 127;
        if (qv >= 64'd16777216) begin
            frac = (qv / 2) % 64'd8388608;
        end else begin
            frac = qv % 64'd8388608;
            e    = e - 1;
        end
        if (e >= 255) return {1'b0, 1'b1, sgn, 8'hFF, 23'h0};
        if (e <= 0)   return {1'b0, 1'b0, sgn, 31'h0};
        return {1'b0, 1'b0, sgn, 8'(e), 23'(frac)};
    endfunction

    // Issue one operation; optionally pulse start with other operands
    // poke_edge edges after acceptance. Returns the result at done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int poke_edge,
                          output logic [31:0] r_out, output logic r_dbz, output logic r_ovf,
                          output int lat, output logic seen, output logic busy_after,
                          output logic pulse_low);
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        busy_after = busy;
        seen       = 1'b0;
        lat        = 0;
        for (int n = 1; n <= MAX_WAIT; n++) begin
            if (n == poke_edge) begin
                in1   = 32'h3F800000;
                in2   = 32'h00000000;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = n;
                break;
            end
        end
        r_out = out;
        r_dbz = div_by_zero;
        r_ovf = overflow;
        @(posedge clk);
        #1;
        pulse_low = ~done;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] r_out;
        logic        r_dbz, r_ovf, seen, busy_after, pulse_low;
        int          lat;
        logic [33:0] exp_r;
        int          done_cnt;

        vecs.push_back('{"6div2",    32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, LAT_NORMAL});
        vecs.push_back('{"1div3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, LAT_NORMAL});
        vecs.push_back('{"m8div2",   32'hC1000000, 32'h40000000, 32'hC0800000, 1'b0, 1'b0, LAT_NORMAL});
        vecs.push_back('{"1div1p5",  32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 1'b0, 1'b0, LAT_NORMAL});
        vecs.push_back('{"divzero",  32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, LAT_BYPASS});
        vecs.push_back('{"zerodiv",  32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, LAT_BYPASS});
        vecs.push_back('{"ovf",      32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b1, LAT_NORMAL});
        vecs.push_back('{"undf",     32'h00800000, 32'h4B000000, 32'h00000000, 1'b0, 1'b0, LAT_NORMAL});
        vecs.push_back('{"negdz",    32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, LAT_BYPASS});

        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out",  out, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_flags", {30'h0, div_by_zero, overflow}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, 0, r_out, r_dbz, r_ovf, lat, seen, busy_after, pulse_low);
            check({vecs[i].name, "_seen"}, 32'(seen), 32'h1);
            check({vecs[i].name, "_out"},  r_out, vecs[i].exp_out);
            check({vecs[i].name, "_dbz"},  32'(r_dbz), 32'(vecs[i].exp_dbz));
            check({vecs[i].name, "_ovf"},  32'(r_ovf), 32'(vecs[i].exp_ovf));
            check({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_busy"}, 32'(busy_after), 32'h1);
            check({vecs[i].name, "_pulse"}, 32'(pulse_low), 32'h1);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i % 8 == 3) a[30:23] = 8'h00;
            if (i % 8 == 5) b[30:23] = 8'h00;
            exp_r = ref_div(a, b);
            run_op(a, b, 0, r_out, r_dbz, r_ovf, lat, seen, busy_after, pulse_low);
            check("rnd_out",  r_out, exp_r[31:0]);
            check("rnd_flag", {30'h0, r_dbz, r_ovf}, {30'h0, exp_r[33:32]});
            check("rnd_lat",  32'(lat), (exp_r[33] || a[30:23] == 8'h00) ? 32'(LAT_BYPASS) : 32'(LAT_NORMAL));
        end

        // start pulsed 5 edges into a division: must not disturb it
        run_op(32'h40C00000, 32'h40000000, 5, r_out, r_dbz, r_ovf, lat, seen, busy_after, pulse_low);
        check("poke_out", r_out, 32'h40400000);
        check("poke_dbz", 32'(r_dbz), 32'h0);
        check("poke_lat", 32'(lat), 32'(LAT_NORMAL));

        // reset 10 edges into a division: all outputs clear, no done later
        @(negedge clk);
        in1   = 32'h3F800000;
        in2   = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_out",  out, 32'h0);
        check("abort_ctl",  {28'h0, busy, done, div_by_zero, overflow}, 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort_nodone", 32'(done_cnt), 32'h0);
        run_op(32'hC1000000, 32'h40000000, 0, r_out, r_dbz, r_ovf, lat, seen, busy_after, pulse_low);
        check("after_abort_out", r_out, 32'hC0800000);
        check("after_abort_lat", 32'(lat), 32'(LAT_NORMAL));

        // start held high through done: ignored in DONE, accepted next IDLE
        @(negedge clk);
        in1   = 32'h40C00000;
        in2   = 32'h40000000;
        start = 1'b1;
        seen  = 1'b0;
        for (int n = 0; n <= MAX_WAIT; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("hold_seen", 32'(seen), 32'h1);
        @(posedge clk);
        #1;
        check("hold_idle", {30'h0, busy, done}, 32'h0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_accept", 32'(busy), 32'h1);
        seen = 1'b0;
        for (int n = 0; n <= MAX_WAIT; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("hold_seen2", 32'(seen), 32'h1);
        check("hold_out", out, 32'h40400000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
